// File: rtl/vec_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : vec_operand_stage
//  Brief    : Operand-fetch / writeback stage for the 4-lane vector ALU.
//             Holds a flop-based vector register file, loads one execute
//             slot per cycle with forwarded operands, and retires the ALU
//             result back into the register file together with NZP flags.
//  Revision : 1.0 - initial release
// ============================================================================
module vec_operand_stage #(
    parameter  int NUM_REGS = 16,
    parameter  int LANE_W   = 32,
    localparam int REG_W    = $clog2(NUM_REGS),
    localparam int VEC_W    = 4 * LANE_W
) (
    input  logic                 clk,
    input  logic                 rst,

    // Decoded instruction handshake
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [REG_W-1:0]     in_dest_reg,
    input  logic [REG_W-1:0]     in_arg_reg,
    input  logic                 in_imm_en,
    input  logic [LANE_W-1:0]    in_imm,
    input  logic [7:0]           in_swizzle,
    input  logic [3:0]           in_write_mask,
    input  logic                 hold,

    // Execute slot driving the ALU
    output logic [VEC_W-1:0]     alu_dest,
    output logic [VEC_W-1:0]     alu_arg,
    output logic [2:0]           alu_op,
    output logic [7:0]           alu_swizzle,
    output logic [3:0]           alu_write_mask,
    input  logic [VEC_W-1:0]     alu_dest_out,
    input  logic [2:0]           alu_nzp,

    // Architectural flags and writeback report
    output logic [2:0]           nzp_flags,
    output logic                 wb_valid,
    output logic [REG_W-1:0]     wb_reg,
    output logic [VEC_W-1:0]     wb_data,

    // Debug read port
    input  logic [REG_W-1:0]     dbg_addr,
    output logic [VEC_W-1:0]     dbg_data
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [VEC_W-1:0]   rf_q [NUM_REGS];
    logic [VEC_W-1:0]   rf_d [NUM_REGS];

    logic               e_valid_q,      e_valid_d;
    logic [REG_W-1:0]   e_dest_reg_q,   e_dest_reg_d;
    logic [VEC_W-1:0]   alu_dest_q,     alu_dest_d;
    logic [VEC_W-1:0]   alu_arg_q,      alu_arg_d;
    logic [2:0]         alu_op_q,       alu_op_d;
    logic [7:0]         alu_swizzle_q,  alu_swizzle_d;
    logic [3:0]         alu_wmask_q,    alu_wmask_d;

    logic [2:0]         nzp_q,          nzp_d;
    logic               wb_valid_q,     wb_valid_d;
    logic [REG_W-1:0]   wb_reg_q,       wb_reg_d;
    logic [VEC_W-1:0]   wb_data_q,      wb_data_d;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic               w_retire;
    logic               w_accept;
    logic [VEC_W-1:0]   w_fwd_dest;
    logic [VEC_W-1:0]   w_fwd_arg;

    // The slot retires and a new instruction enters on the same un-held edge.
    assign w_retire = e_valid_q && !hold;
    assign w_accept = in_valid && !hold;
    assign in_ready = !hold;

    // Operand read with bypass of the value being written back on this edge;
    // dest and arg are bypassed independently so they may name one register.
    always_comb begin
        w_fwd_dest = rf_q[in_dest_reg];
        w_fwd_arg  = rf_q[in_arg_reg];
        if (w_retire && (e_dest_reg_q == in_dest_reg)) begin
            w_fwd_dest = alu_dest_out;
        end
        if (w_retire && (e_dest_reg_q == in_arg_reg)) begin
            w_fwd_arg = alu_dest_out;
        end
    end

    // ------------------------------------------------------------------------
    // Register file: single write port owned by retire
    // ------------------------------------------------------------------------

    // Next register file contents: the full 128-bit result lands on retire.
    always_comb begin
        rf_d = rf_q;
        if (w_retire) begin
            rf_d[e_dest_reg_q] = alu_dest_out;
        end
    end

    // Register file flops, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    assign dbg_data = rf_q[dbg_addr];

    // ------------------------------------------------------------------------
    // Execute slot
    // ------------------------------------------------------------------------

    // Slot load: frozen under hold, emptied when no instruction arrives,
    // and the alu_* payload only changes when something is accepted.
    always_comb begin
        e_valid_d     = e_valid_q;
        e_dest_reg_d  = e_dest_reg_q;
        alu_dest_d    = alu_dest_q;
        alu_arg_d     = alu_arg_q;
        alu_op_d      = alu_op_q;
        alu_swizzle_d = alu_swizzle_q;
        alu_wmask_d   = alu_wmask_q;
        if (!hold) begin
            e_valid_d = in_valid;
        end
        if (w_accept) begin
            e_dest_reg_d  = in_dest_reg;
            alu_dest_d    = w_fwd_dest;
            alu_arg_d     = in_imm_en ? {4{in_imm}} : w_fwd_arg;
            alu_op_d      = in_op;
            alu_swizzle_d = in_swizzle;
            alu_wmask_d   = in_write_mask;
        end
    end

    // Execute slot flops; reset discards any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q     <= 1'b0;
            e_dest_reg_q  <= '0;
            alu_dest_q    <= '0;
            alu_arg_q     <= '0;
            alu_op_q      <= '0;
            alu_swizzle_q <= '0;
            alu_wmask_q   <= '0;
        end else begin
            e_valid_q     <= e_valid_d;
            e_dest_reg_q  <= e_dest_reg_d;
            alu_dest_q    <= alu_dest_d;
            alu_arg_q     <= alu_arg_d;
            alu_op_q      <= alu_op_d;
            alu_swizzle_q <= alu_swizzle_d;
            alu_wmask_q   <= alu_wmask_d;
        end
    end

    assign alu_dest       = alu_dest_q;
    assign alu_arg        = alu_arg_q;
    assign alu_op         = alu_op_q;
    assign alu_swizzle    = alu_swizzle_q;
    assign alu_write_mask = alu_wmask_q;

    // ------------------------------------------------------------------------
    // Flags and writeback report
    // ------------------------------------------------------------------------

    // Flags and writeback record update only on retire; the pulse self-clears.
    always_comb begin
        nzp_d      = nzp_q;
        wb_valid_d = w_retire;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        if (w_retire) begin
            nzp_d     = alu_nzp;
            wb_reg_d  = e_dest_reg_q;
            wb_data_d = alu_dest_out;
        end
    end

    // Flag and writeback flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            nzp_q      <= 3'b000;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            nzp_q      <= nzp_d;
            wb_valid_q <= wb_valid_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign nzp_flags = nzp_q;
    assign wb_valid  = wb_valid_q;
    assign wb_reg    = wb_reg_q;
    assign wb_data   = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vec_operand_stage
//  Brief    : Scoreboard bench for vec_operand_stage with a lane-add ALU model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vec_operand_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [3:0]   in_dest_reg;
    logic [3:0]   in_arg_reg;
    logic         in_imm_en;
    logic [31:0]  in_imm;
    logic [7:0]   in_swizzle;
    logic [3:0]   in_write_mask;
    logic         hold;
    logic [127:0] alu_dest;
    logic [127:0] alu_arg;
    logic [2:0]   alu_op;
    logic [7:0]   alu_swizzle;
    logic [3:0]   alu_write_mask;
    logic [127:0] alu_dest_out;
    logic [2:0]   alu_nzp;
    logic [2:0]   nzp_flags;
    logic         wb_valid;
    logic [3:0]   wb_reg;
    logic [127:0] wb_data;
    logic [3:0]   dbg_addr;
    logic [127:0] dbg_data;

    vec_operand_stage #(.NUM_REGS(16), .LANE_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dest_reg(in_dest_reg), .in_arg_reg(in_arg_reg),
        .in_imm_en(in_imm_en), .in_imm(in_imm), .in_swizzle(in_swizzle),
        .in_write_mask(in_write_mask), .hold(hold),
        .alu_dest(alu_dest), .alu_arg(alu_arg), .alu_op(alu_op),
        .alu_swizzle(alu_swizzle), .alu_write_mask(alu_write_mask),
        .alu_dest_out(alu_dest_out), .alu_nzp(alu_nzp),
        .nzp_flags(nzp_flags), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // ALU model: per-lane dest + swizzled arg, masked lanes keep dest;
    // flags taken from lane 0 of the result.
    always_comb begin
        alu_dest_out = alu_dest;
        for (int l = 0; l < 4; l++) begin
            if (alu_write_mask[l]) begin
                alu_dest_out[l*32 +: 32] = alu_dest[l*32 +: 32]
                    + alu_arg[alu_swizzle[l*2 +: 2]*32 +: 32];
            end
        end
        alu_nzp = {alu_dest_out[31], alu_dest_out[31:0] == 32'd0,
                   !alu_dest_out[31] && (alu_dest_out[31:0] != 32'd0)};
    end

    typedef struct packed {
        logic [127:0] d;
        logic [127:0] a;
    } opexp_t;

    typedef struct packed {
        logic [3:0]   r;
        logic [127:0] data;
        logic [2:0]   nzp;
    } wbexp_t;

    opexp_t op_q[$];
    wbexp_t wb_q[$];

    int vectors     = 0;
    int miscompares = 0;
    logic acc_seen  = 1'b0;

    function automatic logic [127:0] rep(input logic [31:0] x);
        return {4{x}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Handshake tracker for the monitor.
    always @(posedge clk) acc_seen <= in_valid && in_ready && !rst;

    // Monitor: pops operand expectations after each accept and writeback
    // expectations on each wb_valid pulse.
    always @(negedge clk) begin
        if (acc_seen) begin
            if (op_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL op_unexpected: got accept expected none");
            end else begin
                opexp_t e;
                e = op_q.pop_front();
                chk("alu_dest", alu_dest, e.d);
                chk("alu_arg",  alu_arg,  e.a);
            end
        end
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL wb_unexpected: got wb_reg %0d expected no pulse", wb_reg);
            end else begin
                wbexp_t w;
                w = wb_q.pop_front();
                chk("wb_reg",    {124'd0, wb_reg},    {124'd0, w.r});
                chk("wb_data",   wb_data,             w.data);
                chk("nzp_flags", {125'd0, nzp_flags}, {125'd0, w.nzp});
            end
        end
    end

    task automatic issue(input logic [3:0] d, input logic [3:0] a, input logic ie,
                         input logic [31:0] imm, input logic [3:0] m, input logic [7:0] sw,
                         input logic [127:0] ed, input logic [127:0] ea,
                         input logic [127:0] res, input logic [2:0] nzp, input bit wb);
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd1; in_dest_reg = d; in_arg_reg = a;
        in_imm_en = ie; in_imm = imm; in_write_mask = m; in_swizzle = sw;
        op_q.push_back('{d: ed, a: ea});
        if (wb) wb_q.push_back('{r: d, data: res, nzp: nzp});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic chk_reg(input logic [3:0] r, input logic [127:0] exp);
        dbg_addr = r;
        #1;
        chk($sformatf("dbg_R%0d", r), dbg_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; hold = 1'b0; in_valid = 1'b0; in_op = '0;
        in_dest_reg = '0; in_arg_reg = '0; in_imm_en = 1'b0; in_imm = '0;
        in_swizzle = 8'hE4; in_write_mask = 4'hF; dbg_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_wb_valid", {127'd0, wb_valid}, 128'd0);
        chk("rst_nzp", {125'd0, nzp_flags}, 128'd0);
        chk("rst_alu_dest", alu_dest, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        for (int r = 0; r < 16; r++) chk_reg(r[3:0], 128'd0);

        // Single op with forwarding chain on R1: 0+5, then 5+3
        issue(4'd1, 4'd0, 1'b1, 32'd5, 4'hF, 8'hE4, 128'd0, rep(32'd5), rep(32'd5), 3'b001, 1'b1);
        issue(4'd1, 4'd0, 1'b1, 32'd3, 4'hF, 8'hE4, rep(32'd5), rep(32'd3), rep(32'd8), 3'b001, 1'b1);
        idle(1);
        // R2 = 1, bubble, then dependent R2+R2 twice
        issue(4'd2, 4'd0, 1'b1, 32'd1, 4'hF, 8'hE4, 128'd0, rep(32'd1), rep(32'd1), 3'b001, 1'b1);
        idle(1);
        issue(4'd2, 4'd2, 1'b0, 32'd0, 4'hF, 8'hE4, rep(32'd1), rep(32'd1), rep(32'd2), 3'b001, 1'b1);
        issue(4'd2, 4'd2, 1'b0, 32'd0, 4'hF, 8'hE4, rep(32'd2), rep(32'd2), rep(32'd4), 3'b001, 1'b1);
        idle(2);
        chk_reg(4'd1, rep(32'd8));
        chk_reg(4'd2, rep(32'd4));

        // Same register on both operands, accepted at the retire edge of R3 = A
        issue(4'd3, 4'd0, 1'b1, 32'hA, 4'hF, 8'hE4, 128'd0, rep(32'hA), rep(32'hA), 3'b001, 1'b1);
        issue(4'd3, 4'd3, 1'b0, 32'd0, 4'hF, 8'hE4, rep(32'hA), rep(32'hA), rep(32'h14), 3'b001, 1'b1);
        idle(2);

        // Hold for 3 cycles with a pending slot and an unaccepted request
        issue(4'd4, 4'd0, 1'b1, 32'd7, 4'hF, 8'hE4, 128'd0, rep(32'd7), rep(32'd7), 3'b001, 1'b1);
        @(negedge clk);
        hold = 1'b1; in_valid = 1'b1; in_dest_reg = 4'd5; in_imm = 32'd99;
        dbg_addr = 4'd4;
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold_alu_dest", alu_dest, 128'd0);
            chk("hold_alu_arg", alu_arg, rep(32'd7));
            chk("hold_wb_valid", {127'd0, wb_valid}, 128'd0);
            chk("hold_in_ready", {127'd0, in_ready}, 128'd0);
            chk("hold_R4", dbg_data, 128'd0);
        end
        @(negedge clk);
        hold = 1'b0; in_valid = 1'b0;
        idle(2);
        chk_reg(4'd4, rep(32'd7));
        chk_reg(4'd5, 128'd0);

        // Negative and zero flags
        issue(4'd6, 4'd0, 1'b1, 32'hFFFF_FFF0, 4'hF, 8'hE4, 128'd0, rep(32'hFFFF_FFF0), rep(32'hFFFF_FFF0), 3'b100, 1'b1);
        issue(4'd7, 4'd0, 1'b1, 32'd0, 4'hF, 8'hE4, 128'd0, 128'd0, 128'd0, 3'b010, 1'b1);
        // Partial write mask, then broadcast swizzle of the non-uniform result
        issue(4'd1, 4'd0, 1'b1, 32'd1, 4'b0001, 8'hE4, rep(32'd8), rep(32'd1),
              {32'd8, 32'd8, 32'd8, 32'd9}, 3'b001, 1'b1);
        issue(4'd8, 4'd1, 1'b0, 32'd0, 4'hF, 8'h00, 128'd0, {32'd8, 32'd8, 32'd8, 32'd9},
              rep(32'd9), 3'b001, 1'b1);
        idle(2);
        chk_reg(4'd8, rep(32'd9));
        chk_reg(4'd3, rep(32'h14));

        // Reset with a live slot: discarded, everything cleared
        issue(4'd9, 4'd0, 1'b1, 32'h55, 4'hF, 8'hE4, 128'd0, rep(32'h55), 128'd0, 3'b000, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_in_ready_mid", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_nzp", {125'd0, nzp_flags}, 128'd0);
        chk("mid_rst_wb_valid", {127'd0, wb_valid}, 128'd0);
        chk("mid_rst_alu_arg", alu_arg, 128'd0);
        for (int r = 0; r < 16; r++) chk_reg(r[3:0], 128'd0);
        idle(3);
        chk("post_rst_wb_valid", {127'd0, wb_valid}, 128'd0);

        chk("op_queue_left", 128'(op_q.size()), 128'd0);
        chk("wb_queue_left", 128'(wb_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
